// File: rtl/stopwatch_mode_ctrl.sv
// stopwatch_mode_ctrl
// Turns raw board buttons and switches into the registered 2-bit stopwatch mode.
// It also generates a one-cycle clear strobe for the minute and second counters.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   btn_pause  raw bouncing pause/resume button (asynchronous)
//   btn_clr    raw bouncing clear button (asynchronous)
//   sw_adj     raw adjust-mode switch, 1 = adjust
//   sw_sel     raw adjust-select switch, 0 = minutes, 1 = seconds
//   cur_state  registered mode: 00 NORMAL, 01 PAUSED, 10 ADJMIN, 11 ADJSEC
//   paused     registered pause flag
//   clr_pulse  registered one-cycle counter clear strobe
module stopwatch_mode_ctrl #(
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned DB_W      = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_pause,
  input  logic       btn_clr,
  input  logic       sw_adj,
  input  logic       sw_sel,
  output logic [1:0] cur_state,
  output logic       paused,
  output logic       clr_pulse
);

  localparam int unsigned NUM_IN    = 4;
  localparam int unsigned NUM_BTN   = 2;
  localparam int unsigned IDX_PAUSE = 0;
  localparam int unsigned IDX_CLR   = 1;
  localparam int unsigned IDX_ADJ   = 2;
  localparam int unsigned IDX_SEL   = 3;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_NORMAL = 2'b00,
    ST_PAUSED = 2'b01,
    ST_ADJMIN = 2'b10,
    ST_ADJSEC = 2'b11
  } state_e;

  // Raw inputs gathered so the synchroniser is one vector of flops.
  logic [NUM_IN-1:0] raw_c;
  logic [NUM_IN-1:0] sync1_q, sync1_d;
  logic [NUM_IN-1:0] sync2_q, sync2_d;

  logic [NUM_BTN-1:0] btn_s_c;
  logic               sw_adj_s_c;
  logic               sw_sel_s_c;

  logic [NUM_BTN-1:0] db_q, db_d;
  logic [NUM_BTN-1:0] db_hist_q, db_hist_d;
  logic [DB_W-1:0]    cnt_q [NUM_BTN];
  logic [DB_W-1:0]    cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] press_c;

  logic   paused_q, paused_d;
  logic   clr_pulse_q, clr_pulse_d;
  state_e state_q, state_d;

  assign raw_c = {sw_sel, sw_adj, btn_clr, btn_pause};

  // Two-flop synchroniser for all four raw inputs.
  always_comb begin
    sync1_d = raw_c;
    sync2_d = sync1_q;
  end

  assign btn_s_c    = sync2_q[NUM_BTN-1:0];
  assign sw_adj_s_c = sync2_q[IDX_ADJ];
  assign sw_sel_s_c = sync2_q[IDX_SEL];

  // Debouncers: the level only follows the input after DB_CYCLES
  // consecutive differing samples; any agreement restarts the count.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_d[i] = '0;
      if (btn_s_c[i] != db_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          db_d[i] = btn_s_c[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Rising edge of the debounced level is a press; releases are ignored.
  always_comb begin
    db_hist_d = db_q;
    press_c   = db_q & ~db_hist_q;
  end

  // Pause/clear handling and mode selection. Clear takes priority over
  // pause, and pause presses are dropped while in adjust mode so the
  // preserved flag decides where we land when adjust is left.
  always_comb begin
    paused_d    = paused_q;
    clr_pulse_d = 1'b0;
    state_d     = ST_NORMAL;

    if (press_c[IDX_CLR]) begin
      clr_pulse_d = 1'b1;
      paused_d    = 1'b0;
    end else if (press_c[IDX_PAUSE] && !sw_adj_s_c) begin
      paused_d    = ~paused_q;
    end

    if (sw_adj_s_c) begin
      state_d = sw_sel_s_c ? ST_ADJSEC : ST_ADJMIN;
    end else begin
      state_d = paused_d ? ST_PAUSED : ST_NORMAL;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      db_q        <= '0;
      db_hist_q   <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= '0;
      end
      paused_q    <= 1'b0;
      clr_pulse_q <= 1'b0;
      state_q     <= ST_NORMAL;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_q        <= db_d;
      db_hist_q   <= db_hist_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      paused_q    <= paused_d;
      clr_pulse_q <= clr_pulse_d;
      state_q     <= state_d;
    end
  end

  assign cur_state = state_q;
  assign paused    = paused_q;
  assign clr_pulse = clr_pulse_q;

endmodule

// File: doc/stopwatch_mode_ctrl.md
Name: stopwatch_mode_ctrl

Overview:
Top-level mode controller for the stopwatch. It turns raw board buttons and switches into the 2-bit stopwatch state that drives the counter-enable and blink-enable decode stage. It also produces a one-cycle clear strobe for the minute and second counters. The block owns input synchronisation, button debouncing, the pause toggle and the adjust-mode selection.

Parameters:
DB_CYCLES, 1000000, consecutive stable clk cycles required before a debounced button level changes (10 ms at 100 MHz).
DB_W, 20, debounce counter width; DB_CYCLES-1 must fit in DB_W bits.

Ports:
clk  input  1  system clock; all logic is on its rising edge.
rst  input  1  synchronous, active-high reset.
btn_pause  input  1  raw, asynchronous, bouncing pause/resume button.
btn_clr  input  1  raw, asynchronous, bouncing clear button.
sw_adj  input  1  raw adjust-mode switch; 1 = adjust mode.
sw_sel  input  1  raw adjust-select switch; 0 = minutes, 1 = seconds.
cur_state  output  2  registered mode: 00 NORMAL, 01 PAUSED, 10 ADJMIN, 11 ADJSEC.
paused  output  1  registered pause flag.
clr_pulse  output  1  registered one-cycle strobe that clears the minute and second counters.

Behaviour:
- Reset (rst=1 at a clk edge): every synchroniser flop, debounced level, debounce counter, edge-history flop, paused, cur_state and clr_pulse goes to 0. rst overrides all other activity, including a debounce or pulse in progress.
- Synchronisers: each of the four raw inputs passes through a 2-flop synchroniser, giving btn_pause_s, btn_clr_s, sw_adj_s and sw_sel_s. The switches are not debounced.
- Debouncer (one instance per button): holds a debounced level db and a counter cnt.
  - If the synchronised input equals db, cnt clears to 0.
  - Otherwise cnt increments. When cnt == DB_CYCLES-1 and the inputs still differ, db takes the synchronised value and cnt clears.
  - Any glitch shorter than DB_CYCLES cycles produces no db change.
- Edge detect: a press event is a 0->1 transition of a debounced level, measured against a 1-cycle history flop. Each physical press produces exactly one event, however long the button is held. Releases produce no event.
- Clear event, in the cycle after the event is detected:
  - clr_pulse = 1 for exactly one cycle, then 0.
  - paused <= 0.
- Pause event, with no clear event and sw_adj_s = 0: paused <= ~paused.
- Pause event while sw_adj_s = 1: ignored; paused is held.
- Simultaneous clear and pause events in one cycle: clear wins; paused <= 0 and there is no toggle.
- cur_state register is updated every cycle from the next-state values:
  - sw_adj_s=1, sw_sel_s=0 -> 10 (ADJMIN).
  - sw_adj_s=1, sw_sel_s=1 -> 11 (ADJSEC).
  - sw_adj_s=0 -> {1'b0, next paused}; 01 if paused, else 00.
  - cur_state and paused therefore change in the same cycle.
- Leaving adjust mode returns to NORMAL or PAUSED according to the preserved paused flag.
- clr_pulse is allowed in any state, including adjust modes.
- Latency, raw pin change to output:
  - Switches: 3 cycles (2 synchroniser + 1 state register).
  - Buttons: 2 (synchroniser) + DB_CYCLES (debounce) + 1 (register).
- There are no illegal states; all four cur_state encodings are reachable and decoded.

Test Plan (DB_CYCLES=4, DB_W=3):
1. Reset then idle: assert rst for 2 cycles with all inputs 0 -> cur_state=00, paused=0, clr_pulse=0 for at least 20 cycles; assert rst mid-debounce -> the counter restarts and no event fires.
2. Clean pause press: btn_pause 0->1 held 20 cycles -> paused=1 and cur_state=01 exactly 7 cycles after the pin edge, with a single toggle. A second press -> cur_state=00.
3. Bounce rejection: btn_pause pulses high for 3 cycles, low for 2, high for 3, then stays low -> no toggle and cur_state stays 00. Held high for 4 or more stable cycles -> one toggle.
4. Adjust modes: from PAUSED, set sw_adj=1, sw_sel=0 -> cur_state=10 after 3 cycles. Then sw_sel=1 -> 11. Press pause -> stays 11 and paused stays 1. Then sw_adj=0 -> 01.
5. Clear: from PAUSED, press btn_clr -> clr_pulse high for exactly 1 cycle, 7 cycles after the edge, with paused=0 and cur_state=00 in that same cycle. Holding btn_clr produces no further pulses.
6. Simultaneous: from NORMAL, press btn_pause and btn_clr on the same cycle -> one clr_pulse, paused=0 and cur_state=00, with no toggle to 01.
